// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//
// Instruction-fetch stage that sits after the program counter register. It
// keeps at most one instruction-memory request outstanding. Each returned word
// is loaded into the IF/ID register. The stage also drives the PC register's
// write port with either the sequential PC + PC_STEP or a redirect target from
// execute. Stall, flush and the discard of an abandoned in-flight request are
// all handled here.
//
// Ports
//   clk_i          clock, rising edge
//   res_ni         asynchronous active-low reset
//   pc_i           current PC register value
//   pc_write_o     PC register write enable (combinational)
//   pc_next_o      PC register write data (combinational)
//   imem_req_o     instruction memory request
//   imem_addr_o    request address, stable until the transaction completes
//   imem_ready_i   memory completes the request this cycle
//   imem_rdata_i   returned word, valid when imem_req_o && imem_ready_i
//   stall_i        decode cannot consume IF/ID this cycle
//   redirect_i     taken branch/jump: flush and refetch from redirect_pc_i
//   redirect_pc_i  redirect target
//   if_valid_o     IF/ID holds a valid instruction
//   if_pc_o        PC of the IF/ID instruction
//   if_instr_o     IF/ID instruction (NOP_INSTR when invalid or flushed)

module if_fetch_stage #(
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        res_ni,
    input  logic [31:0] pc_i,
    output logic        pc_write_o,
    output logic [31:0] pc_next_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StBuf,
        StDrop
    } state_e;

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;

    logic slot_free;
    logic done;
    logic flush;

    // Request side and PC write port.
    always_comb begin
        slot_free = !if_valid_q || !stall_i;
        // A request that has been seen without ready keeps its latched address.
        imem_addr_o = pending_q ? req_addr_q : pc_i;

        imem_req_o = 1'b0;
        unique case (state_q)
            StIdle: imem_req_o = 1'b0;
            StReq:  imem_req_o = pending_q || slot_free;
            StBuf:  imem_req_o = 1'b0;
            StDrop: imem_req_o = 1'b1;
        endcase

        done  = imem_req_o && imem_ready_i;
        flush = (state_q != StIdle) && redirect_i;

        pc_write_o = 1'b0;
        pc_next_o  = 32'h0;
        if (flush) begin
            // Redirect wins over the sequential increment in the same cycle.
            pc_write_o = 1'b1;
            pc_next_o  = redirect_pc_i;
        end else if ((state_q == StReq) && done) begin
            pc_write_o = 1'b1;
            pc_next_o  = imem_addr_o + PC_STEP;
        end
    end

    // Next-state for the FSM, the outstanding-request tracking, skid and IF/ID.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        req_addr_d   = req_addr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;

        if (flush) begin
            if_valid_d   = 1'b0;
            if_instr_d   = NOP_INSTR;
            skid_pc_d    = 32'h0;
            skid_instr_d = NOP_INSTR;
            if (imem_req_o && !imem_ready_i) begin
                // The memory still owes us a word for the old path: eat it first.
                state_d    = StDrop;
                pending_d  = 1'b1;
                req_addr_d = imem_addr_o;
            end else begin
                state_d   = StReq;
                pending_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StReq;
                end
                StReq: begin
                    if (done) begin
                        pending_d = 1'b0;
                        if (slot_free) begin
                            if_valid_d = 1'b1;
                            if_pc_d    = imem_addr_o;
                            if_instr_d = imem_rdata_i;
                        end else begin
                            skid_pc_d    = imem_addr_o;
                            skid_instr_d = imem_rdata_i;
                            state_d      = StBuf;
                        end
                    end else begin
                        if (imem_req_o) begin
                            pending_d  = 1'b1;
                            req_addr_d = imem_addr_o;
                        end
                        if (slot_free) begin
                            if_valid_d = 1'b0;
                            if_instr_d = NOP_INSTR;
                        end
                    end
                end
                StBuf: begin
                    if (slot_free) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = skid_pc_q;
                        if_instr_d = skid_instr_q;
                        state_d    = StReq;
                    end
                end
                StDrop: begin
                    if (done) begin
                        pending_d = 1'b0;
                        state_d   = StReq;
                    end
                    if (slot_free) begin
                        if_valid_d = 1'b0;
                        if_instr_d = NOP_INSTR;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge res_ni) begin
        if (!res_ni) begin
            state_q      <= StIdle;
            pending_q    <= 1'b0;
            req_addr_q   <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= NOP_INSTR;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 32'h0;
            if_instr_q   <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            req_addr_q   <= req_addr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
        end
    end

    assign if_valid_o = if_valid_q;
    assign if_pc_o    = if_pc_q;
    assign if_instr_o = if_instr_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage.
//
// The bench owns the PC register and a memory whose word at address A is
// A ^ 32'hA5A5_0000. Program order is modelled abstractly. After reset the
// stream runs sequentially from 0. After a redirect it runs sequentially from
// the target. Stimulus pushes that expected stream into a queue. A monitor pops
// one entry each time decode consumes IF/ID. The monitor also tracks whether an
// abandoned request is still owed by memory, and it uses that to predict the
// PC write port.

module tb_if_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] XORK = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk = 1'b0;
    logic        res_n;
    logic [31:0] pc_q;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] junk;

    int n_checks   = 0;
    int n_pass     = 0;
    int n_consumed = 0;

    fetch_t exp_q[$];

    always #5 clk = ~clk;

    // PC register downstream of the stage's write port.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) pc_q <= 32'h0;
        else if (pc_write) pc_q <= pc_next;
    end

    assign imem_rdata = (imem_req && imem_ready) ? (imem_addr ^ XORK) : junk;

    if_fetch_stage dut (
        .clk_i         (clk),
        .res_ni        (res_n),
        .pc_i          (pc_q),
        .pc_write_o    (pc_write),
        .pc_next_o     (pc_next),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ready_i  (imem_ready),
        .imem_rdata_i  (imem_rdata),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .if_valid_o    (if_valid),
        .if_pc_o       (if_pc),
        .if_instr_o    (if_instr)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    endtask

    // Expected program order from a start address; longer than any run between reseeds.
    task automatic seed(input logic [31:0] start);
        fetch_t f;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            f.pc    = start + 32'(i * 4);
            f.instr = f.pc ^ XORK;
            exp_q.push_back(f);
        end
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect    = 1'b1;
        redirect_pc = tgt;
        seed(tgt);
    endtask

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, so everything it sees is what the next rising
    // edge will act on.
    initial begin : monitor
        int          cyc       = 0;
        logic        discard   = 1'b0;
        logic        prev_wait = 1'b0;
        logic [31:0] prev_addr = 32'h0;
        logic        exp_w;
        logic [31:0] exp_n;
        fetch_t      f;
        forever begin
            @(negedge clk);
            if (!res_n) begin
                check1("reset if_valid", if_valid, 1'b0);
                check1("reset imem_req", imem_req, 1'b0);
                check1("reset pc_write", pc_write, 1'b0);
                check32("reset pc_next", pc_next, 32'h0);
                check32("reset if_pc", if_pc, 32'h0);
                check32("reset if_instr", if_instr, NOP);
                cyc       = 0;
                discard   = 1'b0;
                prev_wait = 1'b0;
            end else begin
                if (!if_valid) check32("invalid slot holds nop", if_instr, NOP);
                if (cyc == 0) begin
                    check1("idle imem_req", imem_req, 1'b0);
                    check1("idle pc_write", pc_write, 1'b0);
                end else begin
                    if (prev_wait) begin
                        check1("req held while waiting", imem_req, 1'b1);
                        check32("addr held while waiting", imem_addr, prev_addr);
                    end
                    if (redirect) begin
                        exp_w = 1'b1;
                        exp_n = redirect_pc;
                    end else if (imem_req && imem_ready && !discard) begin
                        exp_w = 1'b1;
                        exp_n = imem_addr + 32'd4;
                    end else begin
                        exp_w = 1'b0;
                        exp_n = 32'h0;
                    end
                    check1("pc_write", pc_write, exp_w);
                    if (exp_w) check32("pc_next", pc_next, exp_n);
                    if (redirect) discard = imem_req && !imem_ready;
                    else if (imem_req && imem_ready) discard = 1'b0;
                    if (if_valid && !stall && !redirect) begin
                        n_consumed++;
                        if (exp_q.size() == 0) begin
                            check1("scoreboard not empty", 1'b0, 1'b1);
                        end else begin
                            f = exp_q.pop_front();
                            check32("consumed if_pc", if_pc, f.pc);
                            check32("consumed if_instr", if_instr, f.instr);
                        end
                    end
                end
                prev_wait = imem_req && !imem_ready;
                prev_addr = imem_addr;
                cyc++;
            end
        end
    end

    initial begin : stimulus
        int          since;
        logic [31:0] tgt;
        res_n       = 1'b0;
        imem_ready  = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        junk        = 32'hDEAD_BEEF;
        seed(32'h0);
        repeat (2) @(posedge clk);
        #1;
        res_n = 1'b1;

        // Sequential zero-wait fetch from 0.
        @(negedge clk); check1("c1 idle req", imem_req, 1'b0);
        nc(); @(negedge clk);
        check1("c2 req", imem_req, 1'b1);
        check32("c2 addr", imem_addr, 32'h0);
        check32("c2 pc_next", pc_next, 32'h4);
        nc(); @(negedge clk);
        check1("c3 if_valid", if_valid, 1'b1);
        check32("c3 if_pc", if_pc, 32'h0);
        nc(); @(negedge clk); check32("c4 if_pc", if_pc, 32'h4);
        nc(); @(negedge clk); check32("c5 if_pc", if_pc, 32'h8);

        // Redirect coinciding with a zero-wait completion at 0x10.
        nc(); do_redirect(32'h200);
        @(negedge clk);
        check32("redir+done addr", imem_addr, 32'h10);
        check32("redir+done pc_next", pc_next, 32'h200);
        nc(); redirect = 1'b0;
        @(negedge clk);
        check1("after redir if_valid", if_valid, 1'b0);
        check32("after redir addr", imem_addr, 32'h200);
        nc(); do_redirect(32'h100);
        @(negedge clk); check32("c8 if_pc", if_pc, 32'h200);

        // Two wait states at 0x100.
        nc(); redirect = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        check32("wait1 addr", imem_addr, 32'h100);
        check1("wait1 pc_write", pc_write, 1'b0);
        nc(); @(negedge clk);
        check32("wait2 addr", imem_addr, 32'h100);
        nc(); imem_ready = 1'b1;
        @(negedge clk);
        check32("wait done addr", imem_addr, 32'h100);
        check32("wait done pc_next", pc_next, 32'h104);

        // Stall with a valid IF/ID entry: held, no request.
        for (int i = 0; i < 3; i++) begin
            nc(); stall = 1'b1;
            @(negedge clk);
            check1("stall if_valid", if_valid, 1'b1);
            check32("stall if_pc", if_pc, 32'h100);
            check1("stall req", imem_req, 1'b0);
        end
        nc(); stall = 1'b0;
        @(negedge clk);
        check32("unstall addr", imem_addr, 32'h104);
        nc(); imem_ready = 1'b0;
        @(negedge clk);
        check32("c16 if_pc", if_pc, 32'h104);
        check32("c16 addr", imem_addr, 32'h108);

        // Redirect while the request at 0x108 waits: hold, drop, then refetch.
        nc(); do_redirect(32'h200);
        @(negedge clk); check32("redir wait pc_next", pc_next, 32'h200);
        nc(); redirect = 1'b0;
        @(negedge clk);
        check1("drop if_valid", if_valid, 1'b0);
        check32("drop addr", imem_addr, 32'h108);
        nc(); imem_ready = 1'b1;
        @(negedge clk);
        check32("drop done addr", imem_addr, 32'h108);
        check1("drop done no pc_write", pc_write, 1'b0);
        nc(); @(negedge clk);
        check32("refetch addr", imem_addr, 32'h200);
        check1("refetch if_valid", if_valid, 1'b0);

        // Reset in the middle of a wait at 0xFFFF_FFFC.
        nc(); do_redirect(32'hFFFF_FFFC);
        nc(); redirect = 1'b0; imem_ready = 1'b0;
        @(negedge clk); check32("top wait addr", imem_addr, 32'hFFFF_FFFC);
        #2; res_n = 1'b0; seed(32'h0);
        #1;
        check1("async reset req", imem_req, 1'b0);
        check1("async reset pc_write", pc_write, 1'b0);
        nc(); nc(); imem_ready = 1'b1; res_n = 1'b1;
        nc(); @(negedge clk); check32("post reset addr", imem_addr, 32'h0);

        // Fetch at the top of the address space wraps the PC.
        nc(); do_redirect(32'hFFFF_FFFC);
        nc(); redirect = 1'b0;
        @(negedge clk); check32("wrap pc_next", pc_next, 32'h0);
        nc(); @(negedge clk); check32("wrap if_pc", if_pc, 32'hFFFF_FFFC);

        // Randomised traffic.
        since = 0;
        repeat (3000) begin
            nc();
            imem_ready = ($urandom_range(0, 9) < 7);
            stall      = ($urandom_range(0, 9) < 3);
            junk       = $urandom();
            since++;
            if (since > 40 || $urandom_range(0, 99) < 4) begin
                tgt = $urandom();
                if ($urandom_range(0, 7) == 0) tgt[31:8] = '1;
                tgt[1:0] = 2'b00;
                do_redirect(tgt);
                since = 0;
            end else begin
                redirect = 1'b0;
            end
        end
        nc(); redirect = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        repeat (3) nc();
        check1("enough instructions consumed", n_consumed >= 300, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
